// File: rtl/mysystem_fpga_state.sv
// Avalon-MM input port that returns fabric status to the HPS. It synchronizes
// the status bus, latches selected edges per bit, and drives a maskable level irq.
module mysystem_fpga_state #(
    parameter int WIDTH       = 10,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] ARM_DONE = CNT_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } reg_addr_e;

    // Index 0 is the first synchronizer stage; the last stage is the usable value.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;
    logic [CNT_W-1:0]                  arm_q, arm_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  edge_q, edge_d;
    logic                              irq_q, irq_d;

    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] rise, fall, det, clr;
    logic             armed, wr_en;
    logic             unused_wdata;

    assign sync_val     = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^writedata;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d = sync_val;
        armed  = (arm_q == ARM_DONE);
        arm_d  = armed ? arm_q : arm_q + CNT_W'(1);

        rise = sync_val & ~prev_q;
        fall = ~sync_val & prev_q;
        if (EDGE_TYPE == 0) begin
            det = rise;
        end else if (EDGE_TYPE == 1) begin
            det = fall;
        end else begin
            det = rise | fall;
        end

        wr_en  = chipselect & ~write_n;
        mask_d = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        clr    = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        // Set is applied after the clear so a coincident edge is never lost.
        edge_d = (edge_q & ~clr) | (armed ? det : '0);
        irq_d  = |(edge_q & mask_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
            mask_q <= '0;
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (reg_addr_e'(address))
                ADDR_DATA: readdata = 32'(sync_val);
                ADDR_MASK: readdata = 32'(mask_q);
                ADDR_EDGE: readdata = 32'(edge_q);
                default:   readdata = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule
